bram_stream_loader: RTL and testbench



---
 rtl/bram_pkg.sv | 16 +
 rtl/bram_stream_loader.sv | 126 ++++++++++++
 tb/tb_bram_stream_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared BRAM word/address defaults and loader state encoding
package bram_pkg;

    localparam int BRAM_DATA_W = 16;
    localparam int BRAM_ADDR_W = 4;
    localparam int BRAM_DEPTH  = 16;

    typedef enum logic [2:0] {
        FILL_LO   = 3'd0,
        FILL_HI   = 3'd1,
        FLUSH     = 3'd2,
        KICK      = 3'd3,
        WAIT_DONE = 3'd4
    } loader_state_e;

endpackage

// File: rtl/bram_stream_loader.sv
// rtl/bram_stream_loader.sv - packs a byte stream into 16-bit BRAM frames, kicks the BRAM stage
// and waits for its done; reports per-frame checksum and a frame counter.
module bram_stream_loader
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W,
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DEPTH  = BRAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic [15:0]       checksum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       sum_q, sum_d;
    logic [15:0]       checksum_q, checksum_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] word_w;

    assign word_w = {in_data, lo_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL_LO;
            idx_q       <= '0;
            lo_q        <= '0;
            sum_q       <= '0;
            checksum_q  <= '0;
            frame_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            sum_q       <= sum_d;
            checksum_q  <= checksum_d;
            frame_cnt_q <= frame_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        sum_d       = sum_q;
        checksum_d  = checksum_q;
        frame_cnt_d = frame_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            FILL_LO: begin
                if (in_valid) begin
                    lo_d    = in_data;
                    state_d = FILL_HI;
                end
            end
            FILL_HI: begin
                if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = word_w;
                    sum_d     = sum_q + 16'(word_w);
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FILL_LO;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Load here so the new checksum is already visible alongside start.
                checksum_d = sum_q;
                state_d    = KICK;
            end
            KICK: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    sum_d       = '0;
                    idx_d       = '0;
                    state_d     = FILL_LO;
                end
            end
            default: begin
                state_d = FILL_LO;
            end
        endcase
    end

    assign in_ready  = !rst && ((state_q == FILL_LO) || (state_q == FILL_HI));
    assign start     = !rst && (state_q == KICK);
    assign busy      = !rst && !((state_q == FILL_LO) && (idx_q == '0));
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_cnt = frame_cnt_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// tb/tb_bram_stream_loader.sv - scoreboard bench for bram_stream_loader
module tb_bram_stream_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        done = 1'b0;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [15:0] checksum;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic [15:0] exp_ck;
    logic [7:0]  exp_frames = 8'd0;
    logic [7:0]  frame_bytes[32];

    bram_stream_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .done(done),
        .busy(busy), .frame_cnt(frame_cnt), .checksum(checksum)
    );

    always #5 clk = ~clk;

    bit parity = 1'b0;
    bit hi_acc = 1'b0;
    bit prev_start = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            parity = 1'b0;
            hi_acc = 1'b0;
        end else begin
            hi_acc = in_valid && in_ready && parity;
            if (in_valid && in_ready) parity = !parity;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (wr_en !== hi_acc) begin
                failures++;
                $display("FAIL wr_en_timing: got %b expected %b at %0t", wr_en, hi_acc, $time);
            end
            if (wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_write: addr %0d data %h with empty scoreboard", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        failures++;
                        $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                                 wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
            if (start) begin
                start_cnt++;
                checks++;
                if (prev_start) begin
                    failures++;
                    $display("FAIL start_back_to_back: got start in two consecutive cycles");
                end
            end
            prev_start = start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bubble);
        int n;
        if (bubble) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input bit bubble);
        wr_t e;
        exp_ck = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            e.addr = 4'(i);
            e.data = {frame_bytes[2*i+1], frame_bytes[2*i]};
            exp_ck = exp_ck + e.data;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 32; i++) send_byte(frame_bytes[i], bubble);
    endtask

    // Called right after the edge that accepted the last high byte (cycle T).
    task automatic finish_frame(input int delay);
        int s0;
        s0 = start_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        checks++;
        if (in_ready !== 1'b0 || start !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle: got in_ready %b start %b expected 0 0", in_ready, start);
        end
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || checksum !== exp_ck) begin
            failures++;
            $display("FAIL kick_cycle: got start %b checksum %h expected 1 %h", start, checksum, exp_ck);
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || start !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold: got in_ready %b start %b expected 0 0", in_ready, start);
            end
        end
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done = 1'b0;
        in_valid = 1'b0;
        exp_frames = exp_frames + 8'd1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || frame_cnt !== exp_frames) begin
            failures++;
            $display("FAIL after_done: got in_ready %b busy %b frame_cnt %0d expected 1 0 %0d",
                     in_ready, busy, frame_cnt, exp_frames);
        end
        checks++;
        if (start_cnt - s0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL frame_end: got starts %0d pending %0d expected 1 0",
                     start_cnt - s0, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0 || start !== 1'b0 || busy !== 1'b0 ||
            frame_cnt !== 8'd0 || checksum !== 16'd0 || wr_addr !== 4'd0 || wr_data !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy %b wr %b st %b busy %b fc %0d ck %h a %0d d %h expected 0 0 0 0 0 0 0 0",
                     in_ready, wr_en, start, busy, frame_cnt, checksum, wr_addr, wr_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got in_ready %b busy %b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 32; i++) frame_bytes[i] = 8'(i + 1);
        send_frame(1'b0);
        checks++;
        if (exp_ck !== 16'h1100) begin
            failures++;
            $display("FAIL model_checksum: got %h expected 1100", exp_ck);
        end
        finish_frame(0);
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 32; i++) frame_bytes[i] = 8'(8'h40 + i);
        send_frame(1'b0);
        finish_frame(10);
        for (int i = 0; i < 32; i++) frame_bytes[i] = 8'(8'h90 + 3 * i);
        send_frame(1'b0);
        finish_frame(2);
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 32; i++) frame_bytes[i] = 8'(i + 1);
        send_frame(1'b1);
        finish_frame(0);
    endtask

    task automatic test_reset_mid_frame();
        wr_t e;
        int s0;
        for (int i = 0; i < 2; i++) begin
            e.addr = 4'(i);
            e.data = {8'(2 * i + 2), 8'(2 * i + 1)};
            exp_q.push_back(e);
        end
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 8'd0;
        checks++;
        if (frame_cnt !== 8'd0 || checksum !== 16'd0 || busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_state: got fc %0d ck %h busy %b pending %0d expected 0 0 0 0",
                     frame_cnt, checksum, busy, exp_q.size());
        end
        s0 = start_cnt;
        for (int i = 0; i < 32; i++) frame_bytes[i] = 8'hFF;
        send_frame(1'b0);
        checks++;
        if (exp_ck !== 16'hFFF0) begin
            failures++;
            $display("FAIL model_ff_checksum: got %h expected fff0", exp_ck);
        end
        finish_frame(1);
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL mid_reset_starts: got %0d expected 1", start_cnt - s0);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 8'd0;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 32; i++) frame_bytes[i] = 8'($urandom_range(0, 255));
            send_frame(1'b0);
            finish_frame(0);
            if (f == 254) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_255: got %0d expected 255", frame_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap_0: got %0d expected 0", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_pressure();
        test_bubbles();
        test_reset_mid_frame();
        test_wrap();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
